// File: rtl/apb_regfile.sv
// APB register-file slave: NUM_REGS byte-strobed words, fixed wait states,
// error response on out-of-range, misaligned or read-only accesses.
module apb_regfile #(
    parameter int                  DATA_W      = 32,
    parameter int                  ADDR_W      = 12,
    parameter int                  NUM_REGS    = 8,
    parameter int                  WAIT_STATES = 0,
    parameter logic [NUM_REGS-1:0] RO_MASK     = '0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [ADDR_W-1:0]          paddr,
    input  logic [DATA_W-1:0]          pwdata,
    input  logic [DATA_W/8-1:0]        pstrb,
    input  logic                       pwrite,
    input  logic                       psel,
    input  logic                       penable,
    output logic                       pready,
    output logic                       pslverr,
    output logic [DATA_W-1:0]          prdata,
    output logic [NUM_REGS*DATA_W-1:0] regs_o
);

    localparam int          NB         = DATA_W / 8;
    localparam int          IDX_W      = ADDR_W - 2;
    localparam int          SEL_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int          CNT_W      = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam logic [31:0] NUM_REGS_U = NUM_REGS;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [DATA_W-1:0]   r_regs [NUM_REGS];
    logic                r_pready;
    logic                r_pslverr;
    logic [DATA_W-1:0]   r_prdata;

    logic [IDX_W-1:0]    w_idx;
    logic [31:0]         w_idx_ext;
    logic [SEL_W-1:0]    w_sel;
    logic                w_start;
    logic                w_resp_entry;
    logic                w_err;
    logic                w_do_write;

    assign w_idx     = paddr[ADDR_W-1:2];
    assign w_idx_ext = 32'(w_idx);
    assign w_sel     = w_idx[SEL_W-1:0];
    assign w_start   = psel & penable;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next_state;
    end

    // Next-state logic; psel dropping during WAIT aborts the transfer
    always_comb begin
        // NOTE: default assignment first so no path leaves the signal unassigned (no latch).
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_next_state = S_WAIT;
            S_WAIT:  if (!psel) w_next_state = S_IDLE;
                     else if (r_cnt == '0) w_next_state = S_RESP;
            S_RESP:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Output decode: the access happens on the edge that enters RESP
    always_comb begin
        w_resp_entry = (r_state == S_WAIT) && psel && (r_cnt == '0);
        w_err        = 1'b0;
        if (w_idx_ext >= NUM_REGS_U)       w_err = 1'b1;
        else if (paddr[1:0] != 2'b00)      w_err = 1'b1;
        else if (pwrite && RO_MASK[w_sel]) w_err = 1'b1;
        w_do_write   = w_resp_entry && pwrite && !w_err;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (r_state == S_IDLE && w_start) begin
            r_cnt <= CNT_W'(WAIT_STATES);
        end else if (r_state == S_WAIT && r_cnt != '0) begin
            // NOTE: sequential state uses non-blocking assignments only.
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
            r_prdata  <= '0;
        end else begin
            r_pready  <= w_resp_entry;
            r_pslverr <= w_resp_entry && w_err;
            if (w_resp_entry) begin
                if (w_err)        r_prdata <= '0;
                else if (!pwrite) r_prdata <= r_regs[w_sel];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the register file is small flops, not RAM, so it can be reset.
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
        end else if (w_do_write) begin
            for (int b = 0; b < NB; b++)
                if (pstrb[b]) r_regs[w_sel][8*b +: 8] <= pwdata[8*b +: 8];
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_o[g*DATA_W +: DATA_W] = r_regs[g];
    end

    assign pready  = r_pready;
    assign pslverr = r_pslverr;
    assign prdata  = r_prdata;

endmodule

// File: tb/tb_apb_regfile.sv
// Self-checking bench: three register files with different wait states and
// read-only masks, directed scenarios followed by randomized transfers.
module tb_apb_regfile;

    localparam int DW = 32;
    localparam int AW = 12;
    localparam int NR = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_n;
    logic [AW-1:0]  paddr;
    logic [DW-1:0]  pwdata;
    logic [3:0]     pstrb;
    logic           pwrite;
    logic [2:0]     psel_v;
    logic           penable;

    logic           pready_w  [3];
    logic           pslverr_w [3];
    logic [DW-1:0]  prdata_w  [3];
    logic [NR*DW-1:0] regs_w  [3];

    apb_regfile #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR), .WAIT_STATES(0), .RO_MASK(8'h01)) dut0 (
        .clk(clk), .rst_n(rst_n), .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
        .pwrite(pwrite), .psel(psel_v[0]), .penable(penable), .pready(pready_w[0]),
        .pslverr(pslverr_w[0]), .prdata(prdata_w[0]), .regs_o(regs_w[0]));

    apb_regfile #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR), .WAIT_STATES(2), .RO_MASK(8'h80)) dut1 (
        .clk(clk), .rst_n(rst_n), .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
        .pwrite(pwrite), .psel(psel_v[1]), .penable(penable), .pready(pready_w[1]),
        .pslverr(pslverr_w[1]), .prdata(prdata_w[1]), .regs_o(regs_w[1]));

    apb_regfile #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR), .WAIT_STATES(3), .RO_MASK(8'h00)) dut2 (
        .clk(clk), .rst_n(rst_n), .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
        .pwrite(pwrite), .psel(psel_v[2]), .penable(penable), .pready(pready_w[2]),
        .pslverr(pslverr_w[2]), .prdata(prdata_w[2]), .regs_o(regs_w[2]));

    // Reference model: plain register arrays per instance
    logic [DW-1:0] mem     [3][NR];
    logic [DW-1:0] last_rd [3];
    int            ws_tab  [3] = '{0, 2, 3};
    logic [NR-1:0] ro_tab  [3] = '{8'h01, 8'h80, 8'h00};

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            last_rd[k] = '0;
            for (int i = 0; i < NR; i++) mem[k][i] = '0;
        end
    endtask

    task automatic check_regs(input int k);
        for (int i = 0; i < NR; i++)
            check($sformatf("regs_o[%0d] dut%0d", i, k), regs_w[k][i*DW +: DW], mem[k][i]);
    endtask

    // One APB transfer to instance k; abort_at>=0 drops psel after that many WAIT cycles
    task automatic xfer(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [3:0] s, input logic w, input int abort_at);
        int   idx;
        int   ws;
        logic err;
        logic aborted;
        logic [DW-1:0] exp_rd;
        idx = int'(a >> 2);
        ws  = ws_tab[k];
        err = 1'b0;
        if (idx >= NR)                       err = 1'b1;
        else if (a[1:0] != 2'b00)            err = 1'b1;
        else if (w && ro_tab[k][idx] == 1'b1) err = 1'b1;
        if (err)     exp_rd = '0;
        else if (w)  exp_rd = last_rd[k];
        else         exp_rd = mem[k][idx];
        aborted = 1'b0;

        psel_v = 3'b000; psel_v[k] = 1'b1; penable = 1'b0;
        paddr = a; pwdata = d; pstrb = s; pwrite = w;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        check($sformatf("pready early dut%0d", k), pready_w[k], 1'b0);
        for (int c = 1; c <= ws + 1; c++) begin
            if (abort_at == c - 1) begin
                psel_v = 3'b000; penable = 1'b0; aborted = 1'b1;
            end
            @(posedge clk); #1;
            if (aborted || c <= ws) begin
                check($sformatf("pready low c%0d dut%0d", c, k), pready_w[k], 1'b0);
            end else begin
                check($sformatf("pready dut%0d", k), pready_w[k], 1'b1);
                check($sformatf("pslverr dut%0d a=%0h", k, a), pslverr_w[k], err);
                check($sformatf("prdata dut%0d a=%0h", k, a), prdata_w[k], exp_rd);
            end
        end
        psel_v = 3'b000; penable = 1'b0;
        if (!aborted) begin
            last_rd[k] = exp_rd;
            if (w && !err)
                for (int b = 0; b < 4; b++)
                    if (s[b]) mem[k][idx][8*b +: 8] = d[8*b +: 8];
        end
        @(posedge clk); #1;
        check($sformatf("pready clear dut%0d", k), pready_w[k], 1'b0);
        check($sformatf("pslverr clear dut%0d", k), pslverr_w[k], 1'b0);
        check($sformatf("prdata hold dut%0d", k), prdata_w[k], last_rd[k]);
        check_regs(k);
    endtask

    initial begin
        int k;
        int r;
        int ab;
        logic [AW-1:0] a;

        rst_n = 1'b0; psel_v = 3'b000; penable = 1'b0;
        paddr = '0; pwdata = '0; pstrb = '0; pwrite = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        for (int j = 0; j < 3; j++) begin
            check($sformatf("reset pready dut%0d", j), pready_w[j], 1'b0);
            check($sformatf("reset pslverr dut%0d", j), pslverr_w[j], 1'b0);
            check($sformatf("reset prdata dut%0d", j), prdata_w[j], '0);
            check_regs(j);
        end
        rst_n = 1'b1;

        // Reset asserted mid-WAIT on the two-wait-state instance
        xfer(1, 12'h00C, 32'h1234_5678, 4'hF, 1'b1, -1);
        xfer(1, 12'h00C, 32'h0, 4'h0, 1'b0, -1);
        psel_v = 3'b010; penable = 1'b0;
        paddr = 12'h010; pwdata = 32'hCAFE_F00D; pstrb = 4'hF; pwrite = 1'b1;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_regs(1);
        check("rst prdata dut1", prdata_w[1], '0);
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            check($sformatf("rst pready c%0d", c), pready_w[1], 1'b0);
        end
        psel_v = 3'b000; penable = 1'b0;
        rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            check("post-rst pready", pready_w[1], 1'b0);
        end
        check_regs(1);

        // Partial strobes onto zero, then full write and read-back
        xfer(0, 12'h008, 32'hFFFF_FFFF, 4'b0101, 1'b1, -1);
        check("strb 0101 reg2", regs_w[0][2*DW +: DW], 32'h00FF_00FF);
        xfer(0, 12'h008, 32'hDEAD_BEEF, 4'hF, 1'b1, -1);
        xfer(0, 12'h008, 32'h0, 4'h0, 1'b0, -1);
        check("readback reg2", prdata_w[0], 32'hDEAD_BEEF);
        xfer(0, 12'h00C, 32'h5555_5555, 4'h0, 1'b1, -1);

        // Longest latency instance
        xfer(2, 12'h01C, 32'h0BAD_CAFE, 4'hF, 1'b1, -1);
        xfer(2, 12'h01C, 32'h0, 4'hF, 1'b0, -1);

        // Error responses
        xfer(0, 12'h020, 32'h1111_1111, 4'hF, 1'b1, -1);
        xfer(0, 12'h005, 32'h0, 4'hF, 1'b0, -1);
        xfer(0, 12'h000, 32'hAAAA_AAAA, 4'hF, 1'b1, -1);
        check("ro reg0 stays 0", regs_w[0][DW-1:0], 32'h0);
        xfer(0, 12'h000, 32'h0, 4'h0, 1'b0, -1);
        xfer(1, 12'h01C, 32'h7777_7777, 4'hF, 1'b1, -1);

        // Abort during WAIT, then a normal transfer
        xfer(2, 12'h004, 32'h9999_9999, 4'hF, 1'b1, 1);
        xfer(2, 12'h004, 32'h1357_9BDF, 4'hF, 1'b1, -1);
        xfer(1, 12'h008, 32'h2468_ACE0, 4'hF, 1'b1, 0);
        xfer(1, 12'h008, 32'h0, 4'h0, 1'b0, -1);

        // Randomized traffic
        for (int t = 0; t < 300; t++) begin
            k = $urandom_range(0, 2);
            r = $urandom_range(0, 15);
            if (r < 11)      a = AW'($urandom_range(0, 7) * 4);
            else if (r < 13) a = AW'($urandom_range(8, 1023) * 4);
            else             a = AW'($urandom_range(0, 31) * 4 + $urandom_range(1, 3));
            ab = ($urandom_range(0, 9) == 0) ? $urandom_range(0, ws_tab[k]) : -1;
            xfer(k, a, $urandom, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), ab);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
